ctrl_rd_out: RTL
================

// Module: ctrl_rd_out
// PURPOSE
// - Read-back (drain) controller for the BS/BP output buffers filled by the write-back stage.
// - Per tile: reads bs_rd_times BS entries, then bp_rd_times BP entries, into one valid/ready stream toward the DMA/store path.
// - Mirrors the writer's addressing: per-read address = read counter; bank select cycles per read.
// - Credit-limited issue plus skid FIFO: backpressure never drops or duplicates data.
// PARAMETERS
// - BS_COLS           64  LUT-PE columns; BS bank count = BS_COLS/16
// - BP_COLS           32  DSP-PE columns; BP bank count = BP_COLS/8
// - BS_OUT_BUF_DEPTH  10  BS buffer address width
// - BP_OUT_BUF_DEPTH  10  BP buffer address width
// - DATA_W           128  read-data / stream width
// - RD_LAT             2  buffer read latency, req -> data (>=1)
// - FIFO_DEPTH         4  skid FIFO entries (>= RD_LAT+1), power of 2
// PORTS
// - clk               in   1   clock
// - rst_n             in   1   reset, synchronous, active-low
// - bs_rd_times       in   16  BS reads this tile; latched on accepted rd_tile_start
// - bp_rd_times       in   16  BP reads this tile; latched on accepted rd_tile_start
// - rd_tile_start     in   1   start pulse; ignored while rd_busy
// - rd_busy           out  1   high from accepted start through rd_tile_end
// - bs_out_buf_rd_req out  1   BS read strobe
// - bs_out_buf_rd_en  out  3   BS bank select
// - bs_out_buf_rd_addr out BS_OUT_BUF_DEPTH  BS read address
// - bs_rd_data        in   DATA_W  BS data, RD_LAT cycles after req
// - bp_out_buf_rd_req out  1   BP read strobe
// - bp_out_buf_rd_en  out  3   BP bank select
// - bp_out_buf_rd_addr out BP_OUT_BUF_DEPTH  BP read address
// - bp_rd_data        in   DATA_W  BP data, RD_LAT cycles after req
// - out_valid / out_ready  out/in  1  stream handshake
// - out_data          out  DATA_W  stream payload
// - out_is_bs         out  1   1 = beat from BS buffer
// - out_last          out  1   final beat of tile
// - rd_tile_end       out  1   one-cycle pulse, tile fully drained
// - stall_cycles      out  32  backpressure counter (see CONFIGURATION)
// BEHAVIOUR
// - Reset: all outputs 0; FSM IDLE; counters, banks, FIFO, in-flight pipe cleared.
// - FSM IDLE -> RD_BS on start (bs_rd_times != 0).
//   - bs_rd_times == 0 -> RD_BP; both == 0 -> DRAIN, rd_tile_end next cycle, no beats.
// - RD_BS -> RD_BP after read bs_rd_times-1 issues (bp_rd_times == 0 -> DRAIN).
// - RD_BP -> DRAIN after read bp_rd_times-1 issues.
// - DRAIN -> IDLE when the out_last beat handshakes; rd_tile_end pulses that same cycle.
// - Issue: only when credits = FIFO_DEPTH - fifo_count - inflight > 0; max one read/cycle.
//   - *_rd_req high exactly on issue cycles.
// - Counters: addr counter 0..times-1, 16-bit compare cnt == times-1, addr = low bits.
//   - rd_en increments per issue and wraps at bank_count-1.
//   - Both reset to 0 at tile start.
// - Return pipe: RD_LAT-deep shift of {valid, is_bs, last} alongside each issue; captures *_rd_data into FIFO on arrival.
// - last is set on the final issue of the tile: final BP read, or final BS read if bp_rd_times == 0.
// - Stream: out_* driven from FIFO head; held stable while out_valid & ~out_ready.
//   - Push and pop in the same cycle allowed at any occupancy; overflow impossible by credit rule.
// - Order: all BS beats precede all BP beats; within each, address ascending.
// - rd_tile_start while busy: ignored, no state change.
// - Reset mid-tile: immediate abort, in-flight returns discarded, no rd_tile_end.
// CONFIGURATION
// - CTRL_RD_STALL_CNT_EN defined:
//   - stall_cycles counts cycles with out_valid & ~out_ready; saturates at 2^32-1.
//   - Cleared on reset and on accepted rd_tile_start.
// - Undefined: stall_cycles tied to 0, no counter logic.
// TESTING
// - bs=4, bp=2, RD_LAT=2, ready=1 -> 6 beats, is_bs 1,1,1,1,0,0; BS addr 0..3, banks 0,1,2,3; last on beat 6; rd_tile_end same cycle.
// - bs=8, bp=8, ready toggles 1-of-3 -> 16 beats in order, no loss/dup; inflight+fifo_count <= FIFO_DEPTH every cycle.
// - bs=0, bp=3 -> only BP reads, addr 0..2, last on 3rd beat.
// - bs=0, bp=0 -> no req, no beats; rd_tile_end 1 cycle after start.
// - start during busy, then rst_n=0 mid-RD_BP -> second start ignored; after reset all outputs 0; next tile bs=2, bp=1 completes normally.
// - CTRL_RD_STALL_CNT_EN, ready held 0 for 10 cycles with beat pending -> stall_cycles = 10; 0 after next start.

Source files
------------

// File: rtl/ctrl_rd_out.sv
// ctrl_rd_out : drain controller for the BS/BP output buffers.
//
// For each tile it issues bs_rd_times reads of the BS buffer followed by
// bp_rd_times reads of the BP buffer. The returned words are merged into a
// single valid/ready stream. Reads are issued only while the skid FIFO has a
// free slot for every read still in flight. Backpressure therefore stalls
// issue and never drops or duplicates a beat.
//
// Optional feature macro: CTRL_RD_STALL_CNT_EN
//   defined   -> stall_cycles counts out_valid & ~out_ready cycles (saturating),
//                cleared on reset and on an accepted rd_tile_start
//   undefined -> stall_cycles is tied to 0
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   bs_rd_times, bp_rd_times   per-tile read counts, latched on accepted start
//   rd_tile_start              start pulse (ignored while rd_busy)
//   rd_busy                    tile in progress
//   bs_out_buf_rd_req/en/addr  BS read strobe, bank select, address
//   bs_rd_data                 BS read data, RD_LAT cycles after the strobe
//   bp_out_buf_rd_req/en/addr  BP read strobe, bank select, address
//   bp_rd_data                 BP read data, RD_LAT cycles after the strobe
//   out_valid/out_ready        stream handshake
//   out_data/out_is_bs/out_last stream payload, source flag, final beat of tile
//   rd_tile_end                one-cycle pulse when the tile is fully drained
//   stall_cycles               backpressure cycle counter
module ctrl_rd_out #(
    parameter int BS_COLS          = 64,
    parameter int BP_COLS          = 32,
    parameter int BS_OUT_BUF_DEPTH = 10,
    parameter int BP_OUT_BUF_DEPTH = 10,
    parameter int DATA_W           = 128,
    parameter int RD_LAT           = 2,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [15:0]                 bs_rd_times,
    input  logic [15:0]                 bp_rd_times,
    input  logic                        rd_tile_start,
    output logic                        rd_busy,
    output logic                        bs_out_buf_rd_req,
    output logic [2:0]                  bs_out_buf_rd_en,
    output logic [BS_OUT_BUF_DEPTH-1:0] bs_out_buf_rd_addr,
    input  logic [DATA_W-1:0]           bs_rd_data,
    output logic                        bp_out_buf_rd_req,
    output logic [2:0]                  bp_out_buf_rd_en,
    output logic [BP_OUT_BUF_DEPTH-1:0] bp_out_buf_rd_addr,
    input  logic [DATA_W-1:0]           bp_rd_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_is_bs,
    output logic                        out_last,
    output logic                        rd_tile_end,
    output logic [31:0]                 stall_cycles
);

    localparam int BS_BANKS = BS_COLS / 16;
    localparam int BP_BANKS = BP_COLS / 8;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W    = CNT_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RD_BS = 2'd1,
        S_RD_BP = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [15:0] bs_times, bp_times;
    logic        empty_tile;
    logic [15:0] rd_cnt;
    logic [2:0]  bank;

    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] fifo_count;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;

    logic [OCC_W-1:0] occ;
    logic credit_ok;
    logic start_acc;
    logic issue_bs, issue_bp, issue;
    logic bs_final, bp_final, phase_final, issue_last;
    logic [2:0] bank_last;
    logic arrive, push, pop;
    logic [DATA_W-1:0] push_data;

    logic [RD_LAT-1:0] ret_vld_p, ret_is_bs_p, ret_last_p;

    logic [DATA_W-1:0]     fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_is_bs, fifo_last;

    // Issue control: one read per cycle, and only if the FIFO can absorb
    // every read already in flight plus this one.
    assign occ         = OCC_W'(fifo_count) + OCC_W'(inflight);
    assign credit_ok   = (occ < OCC_W'(FIFO_DEPTH));
    assign start_acc   = (state == S_IDLE) && rd_tile_start;
    assign issue_bs    = (state == S_RD_BS) && credit_ok;
    assign issue_bp    = (state == S_RD_BP) && credit_ok;
    assign issue       = issue_bs | issue_bp;
    assign bs_final    = (rd_cnt == bs_times - 16'd1);
    assign bp_final    = (rd_cnt == bp_times - 16'd1);
    assign phase_final = (issue_bs && bs_final) || (issue_bp && bp_final);
    // The tile's last beat is the final BP read, or the final BS read when
    // there is no BP phase at all.
    assign issue_last  = (issue_bs && bs_final && (bp_times == 16'd0)) ||
                         (issue_bp && bp_final);
    assign bank_last   = issue_bs ? 3'(BS_BANKS - 1) : 3'(BP_BANKS - 1);

    assign bs_out_buf_rd_req  = issue_bs;
    assign bs_out_buf_rd_en   = issue_bs ? bank : 3'd0;
    assign bs_out_buf_rd_addr = issue_bs ? rd_cnt[BS_OUT_BUF_DEPTH-1:0] : '0;
    assign bp_out_buf_rd_req  = issue_bp;
    assign bp_out_buf_rd_en   = issue_bp ? bank : 3'd0;
    assign bp_out_buf_rd_addr = issue_bp ? rd_cnt[BP_OUT_BUF_DEPTH-1:0] : '0;

    assign rd_busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        rd_tile_end = 1'b0;
        case (state)
            S_IDLE: begin
                if (rd_tile_start) begin
                    if (bs_rd_times != 16'd0) begin
                        state_nxt = S_RD_BS;
                    end else if (bp_rd_times != 16'd0) begin
                        state_nxt = S_RD_BP;
                    end else begin
                        state_nxt = S_DRAIN;
                    end
                end
            end
            S_RD_BS: begin
                if (issue_bs && bs_final) begin
                    state_nxt = (bp_times != 16'd0) ? S_RD_BP : S_DRAIN;
                end
            end
            S_RD_BP: begin
                if (issue_bp && bp_final) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // An empty tile has no last beat; it ends on its first DRAIN cycle.
                if (empty_tile || (pop && out_last)) begin
                    rd_tile_end = 1'b1;
                    state_nxt   = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Address and bank counters restart at tile start and again at the
    // BS -> BP switch, so each buffer is read from address 0 / bank 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bs_times   <= 16'd0;
            bp_times   <= 16'd0;
            empty_tile <= 1'b0;
            rd_cnt     <= 16'd0;
            bank       <= 3'd0;
        end else if (start_acc) begin
            bs_times   <= bs_rd_times;
            bp_times   <= bp_rd_times;
            empty_tile <= (bs_rd_times == 16'd0) && (bp_rd_times == 16'd0);
            rd_cnt     <= 16'd0;
            bank       <= 3'd0;
        end else if (issue) begin
            if (phase_final) begin
                rd_cnt <= 16'd0;
                bank   <= 3'd0;
            end else begin
                rd_cnt <= rd_cnt + 16'd1;
                bank   <= (bank == bank_last) ? 3'd0 : bank + 3'd1;
            end
        end
    end

    // ---- p0 .. p(RD_LAT-1): return pipe, tracks each read until its data arrives
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ret_vld_p <= '0;
        end else begin
            ret_vld_p[0] <= issue;
            for (int k = 1; k < RD_LAT; k++) begin
                ret_vld_p[k] <= ret_vld_p[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        ret_is_bs_p[0] <= issue_bs;
        ret_last_p[0]  <= issue_last;
        for (int k = 1; k < RD_LAT; k++) begin
            ret_is_bs_p[k] <= ret_is_bs_p[k-1];
            ret_last_p[k]  <= ret_last_p[k-1];
        end
    end

    assign arrive    = ret_vld_p[RD_LAT-1];
    assign push      = arrive;
    assign push_data = ret_is_bs_p[RD_LAT-1] ? bs_rd_data : bp_rd_data;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight <= '0;
        end else begin
            case ({issue, arrive})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // ---- skid FIFO: captures returning words, head drives the stream
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr]  <= push_data;
            fifo_is_bs[wr_ptr] <= ret_is_bs_p[RD_LAT-1];
            fifo_last[wr_ptr]  <= ret_last_p[RD_LAT-1];
        end
    end

    // FIFO storage is not reset, so the payload is masked while empty.
    assign out_valid = (fifo_count != '0);
    assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
    assign out_is_bs = out_valid & fifo_is_bs[rd_ptr];
    assign out_last  = out_valid & fifo_last[rd_ptr];

`ifdef CTRL_RD_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= 32'd0;
        end else if (start_acc) begin
            stall_cycles <= 32'd0;
        end else if (out_valid && !out_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`else
    assign stall_cycles = 32'd0;
`endif

endmodule
